// File: rtl/rr4_arb_pkg.sv
// Shared types and helpers for the 4-way round-robin bus arbiter.
package rr4_arb_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic {IDLE, BUSY} arbState_e;

  // Convert a one-hot vector to its bit index; an all-zero vector maps to 0.
  function automatic logic [SEL_W-1:0] oneHotToIdx(input logic [NREQ-1:0] oh);
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr4_mux4.sv
// 4:1 datapath multiplexer driven by the arbiter select.
module rr4_mux4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  output logic [WIDTH-1:0] y
);

  // Plain select; every sel value is decoded.
  always_comb begin
    y = in0;
    unique case (sel)
      2'd0: y = in0;
      2'd1: y = in1;
      2'd2: y = in2;
      2'd3: y = in3;
      default: y = in0;
    endcase
  end

endmodule

// File: rtl/rr4_pick.sv
// Combinational round-robin picker: first set request scanning from ptr upward, wrapping mod 4.
module rr4_pick
  import rr4_arb_pkg::*;
(
  input  logic [NREQ-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [NREQ-1:0] pickOh;

  // Walk the four positions starting at ptr and keep only the first hit.
  always_comb begin
    pickOh = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[ptr + SEL_W'(i)] && (pickOh == '0)) begin
        pickOh[ptr + SEL_W'(i)] = 1'b1;
      end
    end
  end

  assign found = |pickOh;
  assign idx   = oneHotToIdx(pickOh);

endmodule

// File: rtl/rr4_bus_arbiter.sv
// Round-robin arbiter sharing one output channel among four burst requesters.
// Optional macro RR4_FAST_SWITCH_EN: on release, re-arbitrate in the same cycle
// and hand over directly to another pending requester without an IDLE bubble.
module rr4_bus_arbiter
  import rr4_arb_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [3:0]       last,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [WIDTH-1:0] data_c,
  input  logic [WIDTH-1:0] data_d,
  output logic [3:0]       grant,
  output logic [1:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_src
);

  localparam int unsigned CntW = $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] BurstLimit = CntW'(MAX_BURST);

  arbState_e        stateQ, stateD;
  logic [SEL_W-1:0] selQ, selD;
  logic [SEL_W-1:0] ptrQ, ptrD;
  logic [CntW-1:0]  cntQ, cntD;

  logic [NREQ-1:0]  selOh;
  logic             ownerReq;
  logic             beatAcc;
  logic             burstEnd;
  logic             releaseNow;
  logic [NREQ-1:0]  pickReq;
  logic [SEL_W-1:0] pickPtr;
  logic             pickFound;
  logic [SEL_W-1:0] pickIdx;

  assign selOh    = NREQ'(1) << selQ;
  assign ownerReq = req[selQ];
  assign beatAcc  = out_valid & out_ready;
  assign burstEnd = (cntQ + 1'b1) == BurstLimit;

  // Release on a final beat, on hitting the burst cap, or when the owner withdraws.
  assign releaseNow = (stateQ == BUSY) &&
                      (!ownerReq || (beatAcc && (last[selQ] || burstEnd)));

  // Owner-facing outputs; valid follows the owner's request combinationally.
  assign out_valid = (stateQ == BUSY) & ownerReq;
  assign grant     = beatAcc ? selOh : '0;
  assign select    = selQ;
  assign out_src   = selQ;

`ifdef RR4_FAST_SWITCH_EN
  // While busy, look ahead from the post-release pointer with the owner masked out.
  assign pickReq = (stateQ == BUSY) ? (req & ~selOh) : req;
  assign pickPtr = (stateQ == BUSY) ? (selQ + SEL_W'(1)) : ptrQ;
`else
  assign pickReq = req;
  assign pickPtr = ptrQ;
`endif

  rr4_pick u_pick (
    .req   (pickReq),
    .ptr   (pickPtr),
    .found (pickFound),
    .idx   (pickIdx)
  );

  rr4_mux4 #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel (selQ),
    .in0 (data_a),
    .in1 (data_b),
    .in2 (data_c),
    .in3 (data_d),
    .y   (out_data)
  );

  // Next-state: pick in IDLE, count beats and release in BUSY.
  always_comb begin
    stateD = stateQ;
    selD   = selQ;
    ptrD   = ptrQ;
    cntD   = cntQ;
    unique case (stateQ)
      IDLE: begin
        if (pickFound) begin
          selD   = pickIdx;
          cntD   = '0;
          stateD = BUSY;
        end
      end
      BUSY: begin
        if (beatAcc) cntD = cntQ + 1'b1;
        if (releaseNow) begin
          ptrD   = selQ + SEL_W'(1);
          cntD   = '0;
          stateD = IDLE;
`ifdef RR4_FAST_SWITCH_EN
          if (pickFound) begin
            selD   = pickIdx;
            stateD = BUSY;
          end
`endif
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // State registers; reset drops any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= IDLE;
      selQ   <= '0;
      ptrQ   <= '0;
      cntQ   <= '0;
    end else begin
      stateQ <= stateD;
      selQ   <= selD;
      ptrQ   <= ptrD;
      cntQ   <= cntD;
    end
  end

endmodule

// File: tb/tb_rr4_bus_arbiter.sv
// Directed self-checking bench for rr4_bus_arbiter (WIDTH=32, MAX_BURST=4).
module tb_rr4_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  last;
  logic [31:0] data_a, data_b, data_c, data_d;
  logic [3:0]  grant;
  logic [1:0]  select;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_src;

  int nChecks = 0;
  int nPass   = 0;

  logic [31:0] dataExp [4];

  rr4_bus_arbiter #(
    .WIDTH     (32),
    .MAX_BURST (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .last      (last),
    .data_a    (data_a),
    .data_b    (data_b),
    .data_c    (data_c),
    .data_d    (data_d),
    .grant     (grant),
    .select    (select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    int         k;

    data_a = 32'hA0A0_0001;
    data_b = 32'hDEAD_BEEF;
    data_c = 32'hC0C0_0003;
    data_d = 32'hD0D0_0004;
    dataExp[0] = data_a;
    dataExp[1] = data_b;
    dataExp[2] = data_c;
    dataExp[3] = data_d;
    rst = 1'b1; req = '0; last = '0; out_ready = 1'b0;
    #2;
    checkEq("rst_valid", 32'(out_valid), 32'd0);
    checkEq("rst_grant", 32'(grant), 32'd0);
    checkEq("rst_select", 32'(select), 32'd0);
    step(); step();

    // Reset mid-burst
    rst = 1'b0; req = 4'b0001; last = 4'b0000; out_ready = 1'b1;
    #1;
    checkEq("mid_idle_valid", 32'(out_valid), 32'd0);
    step();
    checkEq("mid_busy_valid", 32'(out_valid), 32'd1);
    checkEq("mid_beat1_grant", 32'(grant), 32'h1);
    checkEq("mid_data", out_data, 32'hA0A0_0001);
    step();
    checkEq("mid_beat2_grant", 32'(grant), 32'h1);
    step();
    rst = 1'b1;
    #1;
    checkEq("mid_rst_valid", 32'(out_valid), 32'd0);
    checkEq("mid_rst_grant", 32'(grant), 32'd0);
    checkEq("mid_rst_select", 32'(select), 32'd0);
    step();
    rst = 1'b0; req = 4'b0000;
    step();

`ifdef RR4_FAST_SWITCH_EN
    // Back-to-back single-beat bursts hand over without a bubble
    req = 4'b0011; last = 4'b0011; out_ready = 1'b1;
    step();
    checkEq("fast_sel0", 32'(select), 32'd0);
    checkEq("fast_v0", 32'(out_valid), 32'd1);
    step();
    checkEq("fast_sel1", 32'(select), 32'd1);
    checkEq("fast_v1", 32'(out_valid), 32'd1);
    step();
    checkEq("fast_sel0b", 32'(select), 32'd0);
    req = 4'b0001;
    #1;
    checkEq("fast_v0b", 32'(out_valid), 32'd1);
    checkEq("fast_grant0b", 32'(grant), 32'h1);
    step();
    checkEq("fast_solo_bubble", 32'(out_valid), 32'd0);
    step();
    checkEq("fast_solo_valid", 32'(out_valid), 32'd1);
    checkEq("fast_solo_sel", 32'(select), 32'd0);
`else
    // All requesting, single-beat bursts: owners 0,1,2,3,0 with a bubble between
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      k  = i % 4;
      oh = 4'b0001 << k;
      step();
      checkEq($sformatf("rr_sel%0d", i), 32'(select), 32'(k));
      checkEq($sformatf("rr_src%0d", i), 32'(out_src), 32'(k));
      checkEq($sformatf("rr_grant%0d", i), 32'(grant), 32'(oh));
      checkEq($sformatf("rr_data%0d", i), out_data, dataExp[k]);
      step();
      checkEq($sformatf("rr_bubble%0d", i), 32'(out_valid), 32'd0);
    end
    req = 4'b0000;
    step();

    // Burst cap: owner 2 with last low gets exactly 4 beats, then 3 is served
    req = 4'b1100; last = 4'b0000;
    step();
    checkEq("cap_sel", 32'(select), 32'd2);
    for (int b = 0; b < 4; b++) begin
      checkEq($sformatf("cap_beat%0d", b), 32'(grant), 32'h4);
      step();
    end
    checkEq("cap_release_valid", 32'(out_valid), 32'd0);
    checkEq("cap_release_grant", 32'(grant), 32'd0);
    step();
    checkEq("cap_next_sel", 32'(select), 32'd3);
    checkEq("cap_next_grant", 32'(grant), 32'h8);
    req = 4'b0000;
    step();
    checkEq("cap_withdraw_idle", 32'(out_valid), 32'd0);

    // Backpressure on owner 1: stalls must not consume burst budget
    req = 4'b0010; last = 4'b0000; out_ready = 1'b0;
    step();
    for (int s = 0; s < 5; s++) begin
      checkEq($sformatf("bp_valid%0d", s), 32'(out_valid), 32'd1);
      checkEq($sformatf("bp_data%0d", s), out_data, 32'hDEAD_BEEF);
      checkEq($sformatf("bp_grant%0d", s), 32'(grant), 32'd0);
      step();
    end
    out_ready = 1'b1;
    #1;
    for (int b = 0; b < 4; b++) begin
      checkEq($sformatf("bp_beat%0d", b), 32'(grant), 32'h2);
      step();
    end
    checkEq("bp_release", 32'(out_valid), 32'd0);

    // Withdrawal: owner 0 drops req before any beat; pending 2 follows after a bubble
    req = 4'b0001; out_ready = 1'b0;
    step();
    checkEq("wd_owner", 32'(select), 32'd0);
    checkEq("wd_valid", 32'(out_valid), 32'd1);
    req = 4'b0100;
    #1;
    checkEq("wd_drop_valid", 32'(out_valid), 32'd0);
    checkEq("wd_drop_grant", 32'(grant), 32'd0);
    step();
    checkEq("wd_idle", 32'(out_valid), 32'd0);
    step();
    checkEq("wd_new_sel", 32'(select), 32'd2);
    checkEq("wd_new_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1; last = 4'b0100;
    #1;
    checkEq("wd_new_grant", 32'(grant), 32'h4);
    checkEq("wd_new_data", out_data, 32'hC0C0_0003);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
